// File: rtl/diff_decode_word.sv
// diff_decode_word: integrates a differential base-4 word, D digits per cycle, MSD first.
// Ports: clk; rst (async, active-low); in_valid/in_ready/word_in accept a word;
// out_valid/out_ready/word_out deliver the decoded word; busy is high while in RUN or DONE.
module diff_decode_word #(
  parameter int N = 100,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] word_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] word_out,
  output logic           busy
);
  localparam int C  = N / D;
  localparam int KW = $clog2(C + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state;
  logic [2*N-1:0] w, nxt;
  logic [1:0]     acc, p;
  logic [KW-1:0]  k;
  logic [2*D-1:0] chunk;
  // w is shifted left each RUN cycle, so the current chunk is always its top D digits
  always_comb begin
    p = acc;
    chunk = '0;
    for (int j = 0; j < D; j++) begin
      p = p + w[2*N-1-2*j -: 2];
      chunk[2*D-1-2*j -: 2] = p;
    end
  end
  // results shift in from the bottom; after C cycles the first chunk sits at the top
  generate
    if (D == N) begin : g_full
      assign nxt = chunk;
    end else begin : g_part
      assign nxt = {word_out[2*N-2*D-1:0], chunk};
    end
  endgenerate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      w         <= '0;
      acc       <= '0;
      k         <= '0;
      word_out  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          w        <= word_in;
          acc      <= '0;
          k        <= '0;
          state    <= RUN;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          w        <= w << (2*D);
          word_out <= nxt;
          acc      <= p;
          k        <= k + 1'b1;
          if (k == KW'(C - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_diff_decode_word.sv
// tb_diff_decode_word: random and directed checks of diff_decode_word against an encoder-based model.
module tb_diff_decode_word;
  localparam int N = 100;
  localparam int C = 25;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [2*N-1:0] word_in, word_out, cur_x;
  logic iv4, ir4, ov4, or4, b4;
  logic [7:0] w4, wo4;
  int vectors = 0;
  int miscompares = 0;
  int m_st, m_cnt, done_cnt;
  logic [2*N-1:0] m_word, m_pend;
  diff_decode_word dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .word_in(word_in), .out_valid(out_valid), .out_ready(out_ready), .word_out(word_out), .busy(busy));
  diff_decode_word #(.N(4), .D(2)) dut4 (.clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .word_in(w4), .out_valid(ov4), .out_ready(or4), .word_out(wo4), .busy(b4));
  always #5 clk = ~clk;
  function automatic logic [199:0] enc(input logic [199:0] x, input int n);
    logic [199:0] r;
    int a, b;
    r = '0;
    for (int i = 0; i < n; i++) begin
      a = int'(x[2*i +: 2]);
      b = 0;
      if (i < n - 1) b = int'(x[2*i+2 +: 2]);
      r[2*i +: 2] = 2'((a - b + 4) % 4);
    end
    return r;
  endfunction
  function automatic logic [199:0] rand200();
    logic [223:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[199:0];
  endfunction
  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // Transaction-level model: a captured word reappears as the original x exactly C edges later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st   <= 0;
      m_cnt  <= 0;
      m_word <= '0;
    end else if (m_st == 0) begin
      if (in_valid) begin
        m_st   <= 1;
        m_cnt  <= 0;
        m_pend <= cur_x;
      end
    end else if (m_st == 1) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == C - 1) begin
        m_st   <= 2;
        m_word <= m_pend;
      end
    end else if (out_ready) begin
      m_st     <= 0;
      done_cnt <= done_cnt + 1;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready", in_ready, m_st == 0);
      chk("busy", busy, m_st != 0);
      chk("out_valid", out_valid, m_st == 2);
      if (m_st != 1) chk("word_out", word_out, m_word);
    end
  end
  task automatic send4(input logic [7:0] wi, input logic [7:0] exp);
    int g, lat;
    g = 0;
    while (!ir4 && g < 50) begin @(negedge clk); g++; end
    chk("d4_idle_wait", g < 50, 1);
    iv4 = 1'b1;
    w4 = wi;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    iv4 = 1'b0;
    w4 = 8'h5A;
    while (!ov4 && lat < 50) begin @(posedge clk); lat++; @(negedge clk); end
    chk("d4_latency", lat, 2);
    chk("d4_word", wo4, exp);
    chk("d4_busy", b4, 1);
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
    chk("d4_ready_after", ir4, 1);
    chk("d4_retain", wo4, exp);
  endtask
  task automatic dsend(input logic [199:0] x, input bit hold);
    int g, lat;
    g = 0;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    chk("idle_wait", g < 200, 1);
    in_valid = 1'b1;
    cur_x = x;
    word_in = enc(x, N);
    out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      in_valid = 1'($urandom_range(1));
      cur_x = rand200();
      word_in = enc(cur_x, N);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, C);
    chk("dec_word", word_out, x);
    if (hold) begin
      repeat (10) begin
        in_valid = 1'($urandom_range(1));
        cur_x = rand200();
        word_in = enc(cur_x, N);
        @(negedge clk);
        chk("hold_word", word_out, x);
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
      end
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask
  initial begin
    int cyc;
    logic [199:0] ones;
    in_valid = 1'b0;
    out_ready = 1'b0;
    word_in = '0;
    cur_x = '0;
    iv4 = 1'b0;
    or4 = 1'b0;
    w4 = '0;
    done_cnt = 0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_out", word_out, 0);
    chk("rst_d4_out", {ov4, b4, wo4}, 0);
    rst = 1'b1;
    chk("pin_enc_6c", enc(200'h7A, 4), 200'h6C);
    chk("pin_enc_ff", enc(200'hE4, 4), 200'hFF);
    for (int i = 0; i < N; i++) ones[2*i +: 2] = 2'd1;
    chk("pin_enc_ones", enc(ones, N), {2'b01, 198'b0});
    send4(8'h6C, 8'h7A);
    send4(8'hFF, 8'hE4);
    send4(8'h00, 8'h00);
    dsend(rand200(), 1'b1);
    dsend(ones, 1'b0);
    cyc = 0;
    while (done_cnt < 1002 && cyc < 80000) begin
      in_valid = ($urandom_range(3) != 0);
      cur_x = rand200();
      word_in = enc(cur_x, N);
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      cyc++;
    end
    chk("random_words_done", done_cnt >= 1002, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (m_st != 0 && cyc < 100) begin @(negedge clk); cyc++; end
    out_ready = 1'b0;
    chk("drain", m_st, 0);
    cur_x = rand200();
    in_valid = 1'b1;
    word_in = enc(cur_x, N);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrun_word_out", word_out, 0);
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    dsend(rand200(), 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
